// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII frame characters, frame geometry, the bit-period helper
// and the double-dabble step used by the time reporter.
package uart_pkg;

  localparam int VALUE_W   = 14;
  localparam int BCD_W     = 16;
  localparam int CONV_W    = BCD_W + VALUE_W;
  localparam int CONV_CYC  = VALUE_W;
  localparam int FRAME_LEN = 8;
  localparam int MAX_VALUE = 9999;

  localparam logic [7:0] CHR_S     = 8'h53;
  localparam logic [7:0] CHR_C     = 8'h43;
  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } frame_state_e;

  function automatic int bitCycles(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  // One shift-add-3 step on {bcd, binary}; digits >= 5 are corrected before the shift.
  function automatic logic [CONV_W-1:0] dabbleStep(input logic [CONV_W-1:0] acc);
    logic [CONV_W-1:0] t;
    t = acc;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (t[VALUE_W + 4*n +: 4] >= 4'd5) begin
        t[VALUE_W + 4*n +: 4] = t[VALUE_W + 4*n +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: baud counter plus 10-bit shift register. A new byte can be
// accepted in the last cycle of the stop bit so consecutive bytes leave no idle gap.
module uart_tx_byte #(
  parameter int BIT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int         CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [3:0] LAST_BIT = 4'd9;

  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_q;
  logic [9:0]       shift_q;
  logic [9:0]       shift_d;
  logic             busy_q;
  logic             tx_q;
  logic             bitEnd;
  logic             lastCycle;
  logic             accept;

  assign bitEnd    = (baud_q == CNT_W'(BIT_CYC - 1));
  assign lastCycle = busy_q && bitEnd && (bit_q == LAST_BIT);
  assign accept    = start_i && (!busy_q || lastCycle);

  // shift_d[0] is always the level the line takes for the bit that begins next.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = {1'b1, data_i, 1'b0};
    end else if (busy_q && bitEnd && !lastCycle) begin
      shift_d = {1'b1, shift_q[9:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      shift_q <= shift_d;
      if (accept) begin
        baud_q <= '0;
        bit_q  <= '0;
        busy_q <= 1'b1;
        tx_q   <= shift_d[0];
      end else if (busy_q) begin
        if (bitEnd) begin
          baud_q <= '0;
          if (lastCycle) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
          end else begin
            bit_q <= bit_q + 4'd1;
            tx_q  <= shift_d[0];
          end
        end else begin
          baud_q <= baud_q + CNT_W'(1);
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = lastCycle;
  assign tx_o   = tx_q;

endmodule

// File: rtl/uart_time_reporter.sv
// Sends the latched display value as "Mdd:dd\r\n" over the UART TX line on request.
// Holds the frame FSM, the double-dabble converter and the frame byte mux.
module uart_time_reporter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               send_req,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_mode,
  output logic               TX,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int BIT_CYC = bitCycles(CLK_FREQ, BAUD);

  frame_state_e       state_q;
  logic [CONV_W-1:0]  conv_q;
  logic               mode_q;
  logic [3:0]         cnt_q;
  logic [2:0]         idx_q;
  logic               lastSent_q;
  logic               start_q;
  logic [7:0]         data_q;
  logic               busy_q;
  logic               done_q;

  logic [VALUE_W-1:0] satValue;
  logic [7:0]         nextByte_d;
  logic [3:0]         digit3;
  logic [3:0]         digit2;
  logic [3:0]         digit1;
  logic [3:0]         digit0;
  logic               byteBusy;
  logic               byteDone;
  logic               byteAccept;

  assign satValue = (i_value > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : i_value;

  assign digit3 = conv_q[VALUE_W + 12 +: 4];
  assign digit2 = conv_q[VALUE_W + 8  +: 4];
  assign digit1 = conv_q[VALUE_W + 4  +: 4];
  assign digit0 = conv_q[VALUE_W      +: 4];

  always_comb begin
    nextByte_d = CHR_LF;
    case (idx_q)
      3'd0:    nextByte_d = mode_q ? CHR_S : CHR_C;
      3'd1:    nextByte_d = CHR_ZERO + {4'd0, digit3};
      3'd2:    nextByte_d = CHR_ZERO + {4'd0, digit2};
      3'd3:    nextByte_d = CHR_COLON;
      3'd4:    nextByte_d = CHR_ZERO + {4'd0, digit1};
      3'd5:    nextByte_d = CHR_ZERO + {4'd0, digit0};
      3'd6:    nextByte_d = CHR_CR;
      default: nextByte_d = CHR_LF;
    endcase
  end

  // The transmitter takes a byte when idle or in its final stop cycle; the same condition
  // lets the FSM stage the following byte early so bytes go out back to back.
  assign byteAccept = start_q && (!byteBusy || byteDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      conv_q     <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      lastSent_q <= 1'b0;
      start_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (send_req) begin
            conv_q  <= {{BCD_W{1'b0}}, satValue};
            mode_q  <= i_mode;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          conv_q <= dabbleStep(conv_q);
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'(CONV_CYC - 1)) begin
            idx_q      <= '0;
            lastSent_q <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_q  <= nextByte_d;
          start_q <= 1'b1;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (byteAccept) begin
            start_q <= 1'b0;
            if (idx_q == 3'(FRAME_LEN - 1)) begin
              lastSent_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_LOAD;
            end
          end else if (lastSent_q && byteDone) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .BIT_CYC(BIT_CYC)
  ) u_tx_byte (
    .clk    (clk),
    .reset  (reset),
    .start_i(start_q),
    .data_i (data_q),
    .busy_o (byteBusy),
    .done_o (byteDone),
    .tx_o   (TX)
  );

  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed bench for uart_time_reporter at 16 clocks per bit; TX, tx_busy and tx_done
// are traced every cycle and frames are compared against hand-written byte strings.
module tb_uart_time_reporter;

  localparam int TRACE_LEN = 20000;
  localparam int BITC      = 16;
  localparam int BYTEC     = 10 * BITC;
  localparam int LAT       = 16;
  localparam int FRAMEC    = 8 * BYTEC;

  localparam logic [63:0] F1  = 64'h5331_323A_3334_0D0A;
  localparam logic [63:0] F2  = 64'h4330_303A_3030_0D0A;
  localparam logic [63:0] F3  = 64'h5339_393A_3939_0D0A;
  localparam logic [63:0] F3C = 64'h4330_303A_3130_0D0A;
  localparam logic [63:0] F4  = 64'h4334_333A_3231_0D0A;
  localparam logic [63:0] F5  = 64'h5331_313A_3131_0D0A;
  localparam logic [63:0] F5B = 64'h4332_323A_3232_0D0A;
  localparam logic [63:0] F6  = 64'h5335_363A_3738_0D0A;

  logic        clk;
  logic        reset;
  logic        send_req;
  logic [13:0] i_value;
  logic        i_mode;
  logic        TX;
  logic        tx_busy;
  logic        tx_done;

  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   failCount = 0;
  logic txTrace   [TRACE_LEN];
  logic busyTrace [TRACE_LEN];
  logic doneTrace [TRACE_LEN];

  uart_time_reporter #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .send_req(send_req),
    .i_value (i_value),
    .i_mode  (i_mode),
    .TX      (TX),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index k of each trace holds the outputs as they stand after rising edge k.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < TRACE_LEN) begin
      txTrace[cyc]   <= TX;
      busyTrace[cyc] <= tx_busy;
      doneTrace[cyc] <= tx_done;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle request; r returns the rising edge that samples it.
  task automatic applyStimulus(input logic [13:0] value, input logic mode, output int r);
    i_value  = value;
    i_mode   = mode;
    send_req = 1'b1;
    r        = cyc + 1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  function automatic logic expLevel(input logic [63:0] frame, input int off);
    int         b;
    int         j;
    logic [7:0] byt;
    b   = off / BYTEC;
    j   = (off % BYTEC) / BITC;
    byt = frame[63 - 8*b -: 8];
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return byt[j-1];
  endfunction

  task automatic checkFrame(input string tag, input int r, input logic [63:0] frame);
    int         waveErr;
    int         busyErr;
    int         doneHits;
    logic [7:0] dec;
    logic [7:0] expB;
    for (int b = 0; b < 8; b++) begin
      expB = frame[63 - 8*b -: 8];
      for (int j = 0; j < 8; j++) begin
        dec[j] = txTrace[r + LAT + b*BYTEC + (j+1)*BITC + BITC/2];
      end
      checkOutput($sformatf("%s byte%0d", tag, b), 32'(dec), 32'(expB));
    end
    waveErr = 0;
    for (int off = 0; off < FRAMEC; off++) begin
      if (txTrace[r + LAT + off] !== expLevel(frame, off)) waveErr++;
    end
    checkOutput({tag, " bit timing"}, 32'(waveErr), 32'd0);
    checkOutput({tag, " idle before start"}, 32'(txTrace[r + LAT - 1]), 32'd1);
    checkOutput({tag, " idle after stop"}, 32'(txTrace[r + LAT + FRAMEC]), 32'd1);
    busyErr = 0;
    for (int i = 0; i < LAT + FRAMEC; i++) begin
      if (busyTrace[r + i] !== 1'b1) busyErr++;
    end
    checkOutput({tag, " busy span"}, 32'(busyErr), 32'd0);
    checkOutput({tag, " busy before req"}, 32'(busyTrace[r - 1]), 32'd0);
    checkOutput({tag, " busy after frame"}, 32'(busyTrace[r + LAT + FRAMEC]), 32'd0);
    doneHits = 0;
    for (int i = -1; i <= LAT + FRAMEC; i++) begin
      if (doneTrace[r + i] === 1'b1) doneHits++;
    end
    checkOutput({tag, " done count"}, 32'(doneHits), 32'd1);
    checkOutput({tag, " done timing"}, 32'(doneTrace[r + LAT + FRAMEC]), 32'd1);
  endtask

  task automatic checkIdle(input string tag, input int from, input int len);
    int lowCnt;
    int busyCnt;
    int doneCnt;
    lowCnt  = 0;
    busyCnt = 0;
    doneCnt = 0;
    for (int i = from; i < from + len; i++) begin
      if (txTrace[i] !== 1'b1) lowCnt++;
      if (busyTrace[i] !== 1'b0) busyCnt++;
      if (doneTrace[i] !== 1'b0) doneCnt++;
    end
    checkOutput({tag, " tx idle"}, 32'(lowCnt), 32'd0);
    checkOutput({tag, " busy idle"}, 32'(busyCnt), 32'd0);
    checkOutput({tag, " no done"}, 32'(doneCnt), 32'd0);
  endtask

  initial begin
    int r1, r2, r3a, r3b, r3c, r4, r5, r5b, r6, r6b, k;
    reset    = 1'b1;
    send_req = 1'b0;
    i_value  = '0;
    i_mode   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset TX", 32'(TX), 32'd1);
    checkOutput("reset tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset tx_done", 32'(tx_done), 32'd0);

    applyStimulus(14'd1234, 1'b1, r1);
    repeat (1310) @(negedge clk);
    checkFrame("t1 1234", r1, F1);

    applyStimulus(14'd0, 1'b0, r2);
    repeat (1310) @(negedge clk);
    checkFrame("t2 0", r2, F2);

    applyStimulus(14'd16383, 1'b1, r3a);
    repeat (1310) @(negedge clk);
    checkFrame("t3 16383", r3a, F3);

    applyStimulus(14'd9999, 1'b1, r3b);
    repeat (1310) @(negedge clk);
    checkFrame("t3 9999", r3b, F3);

    applyStimulus(14'd10, 1'b0, r3c);
    repeat (1310) @(negedge clk);
    checkFrame("t3 10", r3c, F3C);

    // Request during byte 3, then another sampled in the DONE cycle: both dropped.
    applyStimulus(14'd4321, 1'b0, r4);
    repeat (LAT + 3*BYTEC + 40) @(negedge clk);
    i_value  = 14'd9999;
    i_mode   = 1'b1;
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    while (cyc < r4 + LAT + FRAMEC) @(negedge clk);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    repeat (200) @(negedge clk);
    checkFrame("t4 4321", r4, F4);
    checkIdle("t4 ignored reqs", r4 + LAT + FRAMEC + 1, 190);

    // Inputs change mid-frame; a request one cycle after tx_done starts the next frame.
    applyStimulus(14'd1111, 1'b1, r5);
    repeat (300) @(negedge clk);
    i_value = 14'd2222;
    i_mode  = 1'b0;
    while (cyc < r5 + LAT + FRAMEC + 1) @(negedge clk);
    applyStimulus(14'd2222, 1'b0, r5b);
    repeat (1310) @(negedge clk);
    checkFrame("t5 latched", r5, F5);
    checkOutput("t5 back-to-back req edge", 32'(r5b - r5), 32'(LAT + FRAMEC + 2));
    checkFrame("t5 after done", r5b, F5B);

    // Reset lands in a zero data bit of byte 4, together with a request.
    applyStimulus(14'd5678, 1'b1, r6);
    repeat (LAT + 4*BYTEC + 70) @(negedge clk);
    k = cyc;
    checkOutput("t6 TX low before reset", 32'(TX), 32'd0);
    reset    = 1'b1;
    send_req = 1'b1;
    i_value  = 14'd1234;
    @(negedge clk);
    checkOutput("t6 TX after reset", 32'(TX), 32'd1);
    checkOutput("t6 busy after reset", 32'(tx_busy), 32'd0);
    checkOutput("t6 done after reset", 32'(tx_done), 32'd0);
    reset    = 1'b0;
    send_req = 1'b0;
    repeat (1400) @(negedge clk);
    checkIdle("t6 aborted", k + 1, 1400);

    applyStimulus(14'd5678, 1'b1, r6b);
    repeat (1310) @(negedge clk);
    checkFrame("t6 clean", r6b, F6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
